wishbone_mux_n: RTL and testbench
=================================

WISHBONE_MUX_N -- requirements
Module: wishbone_mux_n

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8/16/32/64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 SHALL have parameter NUM_SLAVES, default 4, slave port count (2..16); IW = max(1, clog2(NUM_SLAVES)).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles allowed in ACTIVE before forced error; 0 disables timeout.
REQ-006 SHALL have ports, in order:
 clk  in  1  clock, all state on rising edge;
 rst_n  in  1  reset, asynchronous, active-low;
 wbm_adr_i  in  ADDR_WIDTH  master address;
 wbm_dat_i  in  DATA_WIDTH  master write data;
 wbm_dat_o  out  DATA_WIDTH  read data to master;
 wbm_we_i  in  1  write enable;
 wbm_sel_i  in  SELECT_WIDTH  byte select;
 wbm_stb_i  in  1  strobe;
 wbm_cyc_i  in  1  cycle;
 wbm_ack_o / wbm_err_o / wbm_rty_o  out  1 each  terminations to master;
 wbs_adr_o  out  NUM_SLAVES*ADDR_WIDTH  per-slave address, slave k at slice k;
 wbs_dat_o  out  NUM_SLAVES*DATA_WIDTH  per-slave write data;
 wbs_dat_i  in  NUM_SLAVES*DATA_WIDTH  per-slave read data;
 wbs_we_o / wbs_stb_o / wbs_cyc_o  out  NUM_SLAVES each  per-slave controls;
 wbs_sel_o  out  NUM_SLAVES*SELECT_WIDTH  per-slave byte select;
 wbs_ack_i / wbs_err_i / wbs_rty_i  in  NUM_SLAVES each  per-slave terminations;
 wbs_addr  in  NUM_SLAVES*ADDR_WIDTH  per-slave address prefix;
 wbs_addr_msk  in  NUM_SLAVES*ADDR_WIDTH  per-slave prefix mask;
 busy_o  out  1  state is ACTIVE;
 grant_o  out  IW  latched slave index;
 timeout_o  out  1  one-cycle pulse on timeout.

Function
REQ-007 Slave k SHALL match when ((wbm_adr_i ^ addr_k) & msk_k) == 0; the lowest matching index SHALL win.
REQ-008 The FSM SHALL have states IDLE, ACTIVE, DERR.
REQ-009 IDLE with wbm_cyc_i & wbm_stb_i and a match SHALL latch the winning index into grant_o and go to ACTIVE; no slave output is asserted in that cycle.
REQ-010 IDLE with wbm_cyc_i & wbm_stb_i and no match SHALL go to DERR.
REQ-011 DERR SHALL assert wbm_err_o for exactly one cycle, then return to IDLE.
REQ-012 In ACTIVE, only slave grant_o SHALL see stb = wbm_stb_i, cyc = wbm_cyc_i, we = wbm_we_i; all other slaves' stb/cyc/we SHALL be 0.
REQ-013 adr/dat/sel SHALL be broadcast to every slave unconditionally.
REQ-014 In ACTIVE, wbm_ack_o/err_o/rty_o SHALL equal the granted slave's ack/err/rty combinationally; terminations from ungranted slaves SHALL be ignored.
REQ-015 In ACTIVE, wbm_dat_o SHALL equal the granted slave's dat_i; otherwise wbm_dat_o SHALL be 0.
REQ-016 In ACTIVE, any granted ack|err|rty SHALL return the FSM to IDLE next cycle; a held stb is re-decoded from IDLE, giving a 1-cycle gap between transfers.
REQ-017 In ACTIVE, wbm_cyc_i = 0 SHALL abort to IDLE without any master termination.
REQ-018 Timeout counter: cleared on entry to ACTIVE, increments each ACTIVE cycle without termination, width clog2(TIMEOUT_CYCLES+1).
REQ-019 When the counter reaches TIMEOUT_CYCLES (non-zero) without termination: wbm_err_o=1 and timeout_o=1 for that one cycle, slave stb/cyc forced to 0 that cycle, next state IDLE.
REQ-020 A slave termination arriving in the same cycle as the timeout SHALL take priority; no timeout SHALL be signalled.
REQ-021 With TIMEOUT_CYCLES = 0, ACTIVE SHALL be left only by termination or abort.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, counter 0, grant_o 0, timeout_o 0.
REQ-023 During reset all wbs_stb_o/cyc_o/we_o, wbm_ack_o/err_o/rty_o and busy_o SHALL be 0, and wbm_dat_o SHALL be 0.
REQ-024 Reset asserted mid-ACTIVE SHALL drop the slave stb/cyc asynchronously; no termination SHALL reach the master.

Verification
REQ-025 NUM_SLAVES=4, slave2 addr 0x2000_0000 msk 0xF000_0000; read 0x2000_0010, slave acks with 0xDEADBEEF after 3 cycles -> grant_o=2, only wbs_stb_o[2] high, wbm_dat_o=0xDEADBEEF with wbm_ack_o.
REQ-026 Slaves 1 and 3 both match 0x3000_0000 -> grant_o=1; wbs_ack_i[3] pulsed while granted to 1 -> no wbm_ack_o.
REQ-027 Access to unmapped 0xF000_0000 -> wbm_err_o high exactly one cycle, two cycles after stb; no slave stb.
REQ-028 TIMEOUT_CYCLES=8, granted slave never responds -> wbm_err_o and timeout_o high one cycle on the 8th ACTIVE cycle, then IDLE; repeat with ack on that same cycle -> wbm_ack_o only.
REQ-029 wbm_cyc_i dropped in 2nd ACTIVE cycle -> IDLE next cycle, busy_o=0, no termination; rst_n pulsed low mid-ACTIVE -> all outputs 0 immediately.

Source files
------------

// File: rtl/wishbone_mux_n.sv
// Single-master Wishbone fan-out to NUM_SLAVES ports: prefix/mask address decode,
// lowest-index priority, decode-error response and optional watchdog timeout.
module wishbone_mux_n #(
   parameter  int DATA_WIDTH     = 32,
   parameter  int ADDR_WIDTH     = 32,
   parameter  int SELECT_WIDTH   = DATA_WIDTH / 8,
   parameter  int NUM_SLAVES     = 4,
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int IW             = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [ADDR_WIDTH-1:0]              wbm_adr_i,
   input  logic [DATA_WIDTH-1:0]              wbm_dat_i,
   output logic [DATA_WIDTH-1:0]              wbm_dat_o,
   input  logic                               wbm_we_i,
   input  logic [SELECT_WIDTH-1:0]            wbm_sel_i,
   input  logic                               wbm_stb_i,
   input  logic                               wbm_cyc_i,
   output logic                               wbm_ack_o,
   output logic                               wbm_err_o,
   output logic                               wbm_rty_o,
   output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_adr_o,
   output logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_o,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_i,
   output logic [NUM_SLAVES-1:0]              wbs_we_o,
   output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
   output logic [NUM_SLAVES-1:0]              wbs_stb_o,
   output logic [NUM_SLAVES-1:0]              wbs_cyc_o,
   input  logic [NUM_SLAVES-1:0]              wbs_ack_i,
   input  logic [NUM_SLAVES-1:0]              wbs_err_i,
   input  logic [NUM_SLAVES-1:0]              wbs_rty_i,
   input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr,
   input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr_msk,
   output logic                               busy_o,
   output logic [IW-1:0]                      grant_o,
   output logic                               timeout_o
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DERR} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            hit;
   logic [IW-1:0]   hit_idx;
   logic            active;
   logic            g_ack, g_err, g_rty, g_term;
   logic            tmo;
   logic            slv_en;
   logic [DATA_WIDTH-1:0] g_dat;

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if (((wbm_adr_i ^ wbs_addr[k*ADDR_WIDTH +: ADDR_WIDTH])
              & wbs_addr_msk[k*ADDR_WIDTH +: ADDR_WIDTH]) == '0) begin
            hit     = 1'b1;
            hit_idx = IW'(k);
         end
      end
   end

   assign active = (state_q == S_ACTIVE);
   assign g_ack  = wbs_ack_i[grant_q];
   assign g_err  = wbs_err_i[grant_q];
   assign g_rty  = wbs_rty_i[grant_q];
   assign g_dat  = wbs_dat_i[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
   // Terminations only count while the master still holds the cycle; a dropped cyc is an abort.
   assign g_term = wbm_cyc_i & (g_ack | g_err | g_rty);

   assign tmo = active & wbm_cyc_i & ~g_term & (TIMEOUT_CYCLES != 0)
                & ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

   assign slv_en = active & ~tmo;

   always_comb begin
      wbs_stb_o = '0;
      wbs_cyc_o = '0;
      wbs_we_o  = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         wbs_stb_o[k] = slv_en & (grant_q == IW'(k)) & wbm_stb_i;
         wbs_cyc_o[k] = slv_en & (grant_q == IW'(k)) & wbm_cyc_i;
         wbs_we_o[k]  = slv_en & (grant_q == IW'(k)) & wbm_we_i;
      end
   end

   assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
   assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
   assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};

   assign wbm_ack_o = active & wbm_cyc_i & g_ack;
   assign wbm_err_o = (active & wbm_cyc_i & g_err) | tmo | (state_q == S_DERR);
   assign wbm_rty_o = active & wbm_cyc_i & g_rty;
   assign wbm_dat_o = active ? g_dat : '0;

   assign busy_o    = active;
   assign grant_o   = grant_q;
   assign timeout_o = tmo;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (wbm_cyc_i && wbm_stb_i) begin
               if (hit) begin
                  state_d = S_ACTIVE;
                  grant_d = hit_idx;
                  cnt_d   = '0;
               end else begin
                  state_d = S_DERR;
               end
            end
         end
         S_ACTIVE: begin
            if (!wbm_cyc_i || g_term || tmo) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DERR:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wishbone_mux_n.sv
// Randomized and directed bench for wishbone_mux_n against a transaction-level model.
module tb_wishbone_mux_n;

   localparam int NS = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [AW-1:0]       wbm_adr_i = '0;
   logic [DW-1:0]       wbm_dat_i = '0;
   logic [DW-1:0]       wbm_dat_o;
   logic                wbm_we_i = 1'b0;
   logic [SW-1:0]       wbm_sel_i = '0;
   logic                wbm_stb_i = 1'b0;
   logic                wbm_cyc_i = 1'b0;
   logic                wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [NS*AW-1:0]    wbs_adr_o;
   logic [NS*DW-1:0]    wbs_dat_o;
   logic [NS*DW-1:0]    wbs_dat_i = '0;
   logic [NS-1:0]       wbs_we_o, wbs_stb_o, wbs_cyc_o;
   logic [NS*SW-1:0]    wbs_sel_o;
   logic [NS-1:0]       wbs_ack_i = '0;
   logic [NS-1:0]       wbs_err_i = '0;
   logic [NS-1:0]       wbs_rty_i = '0;
   logic [NS*AW-1:0]    wbs_addr;
   logic [NS*AW-1:0]    wbs_addr_msk;
   logic                busy_o;
   logic [1:0]          grant_o;
   logic                timeout_o;

   logic [AW-1:0] slv_base [NS];
   logic [AW-1:0] slv_msk  [NS];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wishbone_mux_n #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
      .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
      .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
      .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbm_rty_o(wbm_rty_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
      .wbs_dat_i(wbs_dat_i), .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o),
      .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o), .wbs_ack_i(wbs_ack_i),
      .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i), .wbs_addr(wbs_addr),
      .wbs_addr_msk(wbs_addr_msk), .busy_o(busy_o), .grant_o(grant_o),
      .timeout_o(timeout_o)
   );

   // Slave 3 is a narrower window inside slave 1's region, so 0x30xx_xxxx overlaps.
   initial begin
      slv_base[0] = 32'h0000_0000; slv_msk[0] = 32'hF000_0000;
      slv_base[1] = 32'h3000_0000; slv_msk[1] = 32'hF000_0000;
      slv_base[2] = 32'h2000_0000; slv_msk[2] = 32'hF000_0000;
      slv_base[3] = 32'h3000_0000; slv_msk[3] = 32'hFF00_0000;
   end

   always_comb begin
      for (int k = 0; k < NS; k++) begin
         wbs_addr[k*AW +: AW]     = slv_base[k];
         wbs_addr_msk[k*AW +: AW] = slv_msk[k];
      end
   end

   function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   function automatic int decode(logic [AW-1:0] a);
      for (int k = 0; k < NS; k++)
         if ((a & slv_msk[k]) == (slv_base[k] & slv_msk[k])) return k;
      return -1;
   endfunction

   // Model: phase 0 = no transfer, 1 = transfer in flight at slave m_grant,
   // 2 = decode-error reply; m_age counts the cycles the transfer has been in flight.
   int m_phase = 0;
   int m_grant = 0;
   int m_age   = 0;

   initial begin : compare
      logic [NS-1:0] e_stb, e_cyc, e_we;
      logic          e_ack, e_err, e_rty, e_busy, e_to;
      logic [DW-1:0] e_dat;
      int            e_grant, n_phase, n_grant, n_age, g, d;
      logic          term, to;
      forever begin
         @(negedge clk);
         e_stb = '0; e_cyc = '0; e_we = '0;
         e_ack = 0; e_err = 0; e_rty = 0; e_busy = 0; e_to = 0; e_dat = '0;
         if (!rst_n) begin
            m_phase = 0; m_grant = 0; m_age = 0;
            e_grant = 0;
            n_phase = 0; n_grant = 0; n_age = 0;
         end else begin
            e_grant = m_grant;
            n_phase = m_phase; n_grant = m_grant; n_age = m_age;
            if (m_phase == 1) begin
               g    = m_grant;
               term = wbm_cyc_i && (wbs_ack_i[g] || wbs_err_i[g] || wbs_rty_i[g]);
               to   = wbm_cyc_i && !term && (m_age == TO);
               e_busy   = 1;
               e_dat    = wbs_dat_i[g*DW +: DW];
               e_ack    = wbm_cyc_i && wbs_ack_i[g];
               e_rty    = wbm_cyc_i && wbs_rty_i[g];
               e_err    = (wbm_cyc_i && wbs_err_i[g]) || to;
               e_to     = to;
               e_stb[g] = wbm_stb_i && !to;
               e_cyc[g] = wbm_cyc_i && !to;
               e_we[g]  = wbm_we_i && !to;
               if (!wbm_cyc_i || term || to) n_phase = 0;
               else n_age = m_age + 1;
            end else if (m_phase == 2) begin
               e_err   = 1;
               n_phase = 0;
            end else if (wbm_cyc_i && wbm_stb_i) begin
               d = decode(wbm_adr_i);
               if (d >= 0) begin
                  n_phase = 1; n_grant = d; n_age = 1;
               end else begin
                  n_phase = 2;
               end
            end
         end
         chk("busy", busy_o, e_busy);
         chk("grant", grant_o, e_grant);
         chk("ack", wbm_ack_o, e_ack);
         chk("err", wbm_err_o, e_err);
         chk("rty", wbm_rty_o, e_rty);
         chk("timeout", timeout_o, e_to);
         chk("mdat", wbm_dat_o, e_dat);
         chk("sstb", wbs_stb_o, e_stb);
         chk("scyc", wbs_cyc_o, e_cyc);
         chk("swe", wbs_we_o, e_we);
         chk("sadr", wbs_adr_o, {NS{wbm_adr_i}});
         chk("sdat", wbs_dat_o, {NS{wbm_dat_i}});
         chk("ssel", wbs_sel_o, {NS{wbm_sel_i}});
         m_phase = n_phase; m_grant = n_grant; m_age = n_age;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      wbm_cyc_i = 0; wbm_stb_i = 0; wbm_we_i = 0;
      wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0;
   endtask

   task automatic start(input logic [AW-1:0] a);
      wbm_adr_i = a; wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 0; wbm_sel_i = 4'hF;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 7))
         0: return 32'h0000_1234;
         1: return 32'h2000_0010;
         2: return 32'h3000_0040;
         3: return 32'h31AB_0000;
         4: return 32'h3FFF_0000;
         5: return 32'hF000_0000;
         6: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin : stim
      int burst;
      // Reset state
      #2;
      chk("rst_busy", busy_o, 0);
      chk("rst_grant", grant_o, 0);
      chk("rst_stb", wbs_stb_o, 0);
      chk("rst_err", wbm_err_o, 0);
      chk("rst_dat", wbm_dat_o, 0);
      repeat (2) tick();
      rst_n = 1;
      tick();

      // Read from slave 2, acked on the third in-flight cycle
      start(32'h2000_0010);
      @(negedge clk);
      chk("a_decode_stb", wbs_stb_o, 4'b0000);
      chk("a_decode_busy", busy_o, 0);
      tick();
      @(negedge clk);
      chk("a_grant", grant_o, 2);
      chk("a_stb", wbs_stb_o, 4'b0100);
      chk("a_noack", wbm_ack_o, 0);
      tick();
      tick();
      wbs_ack_i[2] = 1; wbs_dat_i[2*DW +: DW] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("a_ack", wbm_ack_o, 1);
      chk("a_dat", wbm_dat_o, 32'hDEAD_BEEF);
      tick();
      idle_bus();
      @(negedge clk);
      chk("a_done", busy_o, 0);
      chk("a_dat_idle", wbm_dat_o, 0);

      // Overlap: slave 1 wins, stray ack from slave 3 ignored
      tick();
      start(32'h3000_0000);
      tick();
      wbs_ack_i[3] = 1;
      @(negedge clk);
      chk("b_grant", grant_o, 1);
      chk("b_stb", wbs_stb_o, 4'b0010);
      chk("b_stray_ack", wbm_ack_o, 0);
      tick();
      wbs_ack_i[3] = 0; wbs_ack_i[1] = 1;
      @(negedge clk);
      chk("b_ack", wbm_ack_o, 1);
      tick();
      idle_bus();

      // Unmapped address -> one-cycle decode error
      tick();
      start(32'hF000_0000);
      @(negedge clk);
      chk("c_err_early", wbm_err_o, 0);
      tick();
      idle_bus();
      @(negedge clk);
      chk("c_err", wbm_err_o, 1);
      chk("c_stb", wbs_stb_o, 0);
      tick();
      @(negedge clk);
      chk("c_err_after", wbm_err_o, 0);

      // Silent slave 0 -> timeout on the 8th in-flight cycle
      tick();
      start(32'h0000_0100);
      for (int i = 1; i <= TO; i++) begin
         tick();
         @(negedge clk);
         if (i < TO) begin
            chk("d_no_to", timeout_o, 0);
         end else begin
            chk("d_to", timeout_o, 1);
            chk("d_err", wbm_err_o, 1);
            chk("d_stb", wbs_stb_o, 0);
            chk("d_cyc", wbs_cyc_o, 0);
         end
      end
      tick();
      idle_bus();
      @(negedge clk);
      chk("d_idle", busy_o, 0);

      // Same, but ack on the timeout cycle wins
      tick();
      start(32'h0000_0100);
      for (int i = 1; i <= TO; i++) begin
         tick();
         if (i == TO) wbs_ack_i[0] = 1;
      end
      @(negedge clk);
      chk("e_ack", wbm_ack_o, 1);
      chk("e_err", wbm_err_o, 0);
      chk("e_to", timeout_o, 0);
      tick();
      idle_bus();

      // Abort by dropping cyc in the second in-flight cycle
      tick();
      start(32'h2000_0000);
      tick();
      tick();
      wbm_cyc_i = 0; wbm_stb_i = 0; wbs_ack_i[2] = 1;
      @(negedge clk);
      chk("f_abort_ack", wbm_ack_o, 0);
      tick();
      wbs_ack_i = '0;
      @(negedge clk);
      chk("f_busy", busy_o, 0);
      chk("f_err", wbm_err_o, 0);

      // Asynchronous reset mid-transfer
      tick();
      start(32'h2000_0000);
      tick();
      wbs_ack_i[2] = 1; wbs_dat_i[2*DW +: DW] = 32'h1234_5678;
      #1 rst_n = 0;
      #1;
      chk("g_stb", wbs_stb_o, 0);
      chk("g_cyc", wbs_cyc_o, 0);
      chk("g_busy", busy_o, 0);
      chk("g_ack", wbm_ack_o, 0);
      chk("g_dat", wbm_dat_o, 0);
      chk("g_grant", grant_o, 0);
      idle_bus();
      tick();
      rst_n = 1;
      tick();

      // Randomized traffic
      burst = 0;
      repeat (2000) begin
         tick();
         for (int k = 0; k < NS; k++) begin
            int r;
            r = $urandom_range(0, 15);
            wbs_ack_i[k] = (r == 0);
            wbs_err_i[k] = (r == 1);
            wbs_rty_i[k] = (r == 2);
            wbs_dat_i[k*DW +: DW] = $urandom;
         end
         if (burst == 0) begin
            if ($urandom_range(0, 2) == 0) begin
               wbm_cyc_i = 1; wbm_stb_i = 1;
               wbm_adr_i = pick_addr();
               wbm_we_i  = 1'($urandom);
               wbm_sel_i = 4'($urandom);
               wbm_dat_i = $urandom;
               burst = $urandom_range(1, 12);
            end else begin
               wbm_cyc_i = 0; wbm_stb_i = 0;
            end
         end else begin
            burst--;
            if ($urandom_range(0, 5) == 0) wbm_stb_i = ~wbm_stb_i;
            if ($urandom_range(0, 7) == 0) wbm_adr_i = pick_addr();
            if (burst == 0) begin
               wbm_cyc_i = 0; wbm_stb_i = 0;
            end
         end
      end
      tick();
      idle_bus();
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
